// File: rtl/vx_tcu_pkg.sv
// Types and constants shared across the TCU FEDP datapath.
package vx_tcu_pkg;

  // Exception flags that travel with a dot-product beat
  typedef struct packed {
    logic invalid;
    logic is_nan;
    logic pos_inf;
    logic neg_inf;
  } fedp_excep_t;

  // fmt_s bit that selects integer (non-floating) accumulation
  localparam int FMT_INT_BIT = 3;

endpackage

// File: rtl/vx_tcu_tfr_align_lane.sv
// Single lane: insert guard bits, right-align to the max exponent, report lost bits.
module vx_tcu_tfr_align_lane #(
  parameter int W     = 25,
  parameter int WA    = 28,
  parameter int EXP_W = 10
) (
  input  logic [W-1:0]     sig,
  input  logic [EXP_W-1:0] shift,
  input  logic             int_mode,
  output logic [WA-1:0]    aligned,
  output logic             lost
);

  localparam int SHW = $clog2(WA);
  localparam logic [EXP_W-1:0] WA_LIM = EXP_W'(WA);

  logic [WA-1:0]  v;
  logic [WA-1:0]  ones;
  logic [SHW-1:0] shift_amt;

  assign v         = {sig, {(WA - W){1'b0}}};
  assign ones      = '1;
  assign shift_amt = shift[SHW-1:0];

  // Integer lanes pass straight through; float lanes shift arithmetically
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    aligned = '0;
    lost    = 1'b0;
    if (int_mode) begin
      aligned = {{(WA - W){sig[W-1]}}, sig};
    end else if (shift >= WA_LIM) begin
      lost = |sig;
    end else begin
      aligned = $signed(v) >>> shift_amt;
      lost    = |(v & ~(ones << shift_amt));
    end
  end

endmodule

// File: rtl/vx_tcu_tfr_align_acc.sv
// Three-stage elastic pipeline: compute shifts, align lanes, sum lanes.
module vx_tcu_tfr_align_acc
  import vx_tcu_pkg::*;
#(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int W     = 25,
  parameter int WA    = 28,
  parameter int EXP_W = 10,
  parameter int SUM_W = WA + $clog2(TCK + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [31:0]              req_id,
  input  logic [3:0]               fmt_s,
  input  logic [EXP_W-1:0]         max_exp,
  input  logic [(TCK+1)*EXP_W-1:0] exponents,
  input  logic [(TCK+1)*W-1:0]     raw_sigs,
  input  fedp_excep_t              exceptions,
  input  logic [TCK-1:0]           lane_mask,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [31:0]              req_id_out,
  output logic [3:0]               fmt_out,
  output logic [SUM_W-1:0]         sum_out,
  output logic                     sticky_out,
  output logic [EXP_W-1:0]         exp_out,
  output fedp_excep_t              exc_out
);

  typedef struct packed {
    logic             valid;
    logic [31:0]      req_id;
    logic [3:0]       fmt;
    logic [EXP_W-1:0] max_exp;
    fedp_excep_t      exc;
  } meta_t;

  typedef struct packed {
    meta_t                      meta;
    logic                       int_mode;
    logic [TCK:0][W-1:0]        sig;
    logic [TCK:0][EXP_W-1:0]    shift;
  } s1_t;

  typedef struct packed {
    meta_t                meta;
    logic [TCK:0][WA-1:0] aligned;
    logic [TCK:0]         lost;
  } s2_t;

  typedef struct packed {
    meta_t            meta;
    logic [SUM_W-1:0] sum;
    logic             sticky;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic                 en;
  logic [TCK:0]         lane_en;
  logic [TCK:0][WA-1:0] lane_aligned;
  logic [TCK:0]         lane_lost;
  logic [SUM_W-1:0]     sum_acc;

  // One global enable: advance everything unless the output is held by the consumer
  assign en       = ~s3_q.meta.valid | ready_out;
  assign ready_in = en;
  assign lane_en  = {1'b1, lane_mask};

  // Stage 1: capture the beat, zero masked lanes, compute per-lane shift
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.meta.valid   = valid_in;
      s1_d.meta.req_id  = req_id;
      s1_d.meta.fmt     = fmt_s;
      s1_d.meta.max_exp = max_exp;
      s1_d.meta.exc     = exceptions;
      s1_d.int_mode     = fmt_s[FMT_INT_BIT];
      for (int i = 0; i <= TCK; i++) begin
        s1_d.sig[i]   = lane_en[i] ? raw_sigs[i*W +: W] : '0;
        s1_d.shift[i] = fmt_s[FMT_INT_BIT] ? '0 : max_exp - exponents[i*EXP_W +: EXP_W];
      end
    end
  end

  for (genvar g = 0; g <= TCK; g++) begin : g_lane
    vx_tcu_tfr_align_lane #(
      .W     (W),
      .WA    (WA),
      .EXP_W (EXP_W)
    ) u_lane (
      .sig      (s1_q.sig[g]),
      .shift    (s1_q.shift[g]),
      .int_mode (s1_q.int_mode),
      .aligned  (lane_aligned[g]),
      .lost     (lane_lost[g])
    );
  end

  // Stage 2: register aligned lane values and their lost-bit flags
  always_comb begin
    s2_d = s2_q;
    if (en) begin
      s2_d.meta    = s1_q.meta;
      s2_d.aligned = lane_aligned;
      s2_d.lost    = lane_lost;
    end
  end

  // Reduction adder over sign-extended aligned lanes
  always_comb begin
    sum_acc = '0;
    for (int i = 0; i <= TCK; i++) begin
      sum_acc = sum_acc + {{(SUM_W - WA){s2_q.aligned[i][WA-1]}}, s2_q.aligned[i]};
    end
  end

  // Stage 3: register the sum and the combined sticky bit
  always_comb begin
    s3_d = s3_q;
    if (en) begin
      s3_d.meta   = s2_q.meta;
      s3_d.sum    = sum_acc;
      s3_d.sticky = |s2_q.lost;
    end
  end

  // Pipeline registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared as well as valids, so outputs read 0 after reset.
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign valid_out  = s3_q.meta.valid;
  assign req_id_out = s3_q.meta.req_id;
  assign fmt_out    = s3_q.meta.fmt;
  assign exp_out    = s3_q.meta.max_exp;
  assign exc_out    = s3_q.meta.exc;
  assign sum_out    = s3_q.sum;
  assign sticky_out = s3_q.sticky;

endmodule

// File: tb/tb_vx_tcu_tfr_align_acc.sv
// Directed vector bench for the align/accumulate pipeline, plus handshake corner cases.
module tb_vx_tcu_tfr_align_acc;
  import vx_tcu_pkg::*;

  localparam int TCK   = 4;
  localparam int W     = 25;
  localparam int EXP_W = 10;
  localparam int SUM_W = 31;
  localparam int NV    = 11;

  logic                     clk;
  logic                     reset;
  logic                     valid_in;
  logic                     ready_in;
  logic [31:0]              req_id;
  logic [3:0]               fmt_s;
  logic [EXP_W-1:0]         max_exp;
  logic [(TCK+1)*EXP_W-1:0] exponents;
  logic [(TCK+1)*W-1:0]     raw_sigs;
  fedp_excep_t              exceptions;
  logic [TCK-1:0]           lane_mask;
  logic                     valid_out;
  logic                     ready_out;
  logic [31:0]              req_id_out;
  logic [3:0]               fmt_out;
  logic [SUM_W-1:0]         sum_out;
  logic                     sticky_out;
  logic [EXP_W-1:0]         exp_out;
  fedp_excep_t              exc_out;

  int errors = 0;
  int checks = 0;

  vx_tcu_tfr_align_acc dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .req_id     (req_id),
    .fmt_s      (fmt_s),
    .max_exp    (max_exp),
    .exponents  (exponents),
    .raw_sigs   (raw_sigs),
    .exceptions (exceptions),
    .lane_mask  (lane_mask),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .req_id_out (req_id_out),
    .fmt_out    (fmt_out),
    .sum_out    (sum_out),
    .sticky_out (sticky_out),
    .exp_out    (exp_out),
    .exc_out    (exc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]              fmt;
    logic [EXP_W-1:0]        max_e;
    logic [4:0][EXP_W-1:0]   exps;
    logic [4:0][W-1:0]       sigs;
    logic [3:0]              mask;
    int                      exp_sum;
    bit                      exp_sticky;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] fmt, input int me,
                              input int e0, input int e1, input int e2, input int e3, input int e4,
                              input int s0, input int s1, input int s2, input int s3, input int s4,
                              input logic [3:0] mask, input int sum, input bit sticky);
    vec_t v;
    v.fmt        = fmt;
    v.max_e      = EXP_W'(me);
    v.exps       = {EXP_W'(e4), EXP_W'(e3), EXP_W'(e2), EXP_W'(e1), EXP_W'(e0)};
    v.sigs       = {W'(s4), W'(s3), W'(s2), W'(s1), W'(s0)};
    v.mask       = mask;
    v.exp_sum    = sum;
    v.exp_sticky = sticky;
    return v;
  endfunction

  // Drive a beat whose only nonzero significand is the C lane
  task automatic drive_c_beat(input int id, input int c_sig);
    valid_in   = 1'b1;
    req_id     = 32'(id);
    fmt_s      = 4'h0;
    max_exp    = 10'd10;
    exponents  = {5{10'd10}};
    raw_sigs   = {W'(c_sig), {(4*W){1'b0}}};
    lane_mask  = 4'h0;
    exceptions = '0;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    valid_in   = 1'b1;
    req_id     = 32'(200 + idx);
    fmt_s      = v.fmt;
    max_exp    = v.max_e;
    exponents  = v.exps;
    raw_sigs   = v.sigs;
    lane_mask  = v.mask;
    exceptions = fedp_excep_t'(4'(idx));
    #1;
    check($sformatf("v%0d ready_in", idx), ready_in, 1);
    @(negedge clk);
    valid_in = 1'b0;
    check($sformatf("v%0d early valid 1", idx), valid_out, 0);
    @(negedge clk);
    check($sformatf("v%0d early valid 2", idx), valid_out, 0);
    @(negedge clk);
    check($sformatf("v%0d valid_out", idx), valid_out, 1);
    check($sformatf("v%0d sum_out", idx), longint'($signed(sum_out)), longint'(v.exp_sum));
    check($sformatf("v%0d sticky_out", idx), sticky_out, v.exp_sticky);
    check($sformatf("v%0d req_id_out", idx), req_id_out, 200 + idx);
    check($sformatf("v%0d exp_out", idx), exp_out, v.max_e);
    check($sformatf("v%0d fmt_out", idx), fmt_out, v.fmt);
    check($sformatf("v%0d exc_out", idx), longint'(exc_out), idx);
  endtask

  initial begin
    // equal exponents, plain sum scaled by the guard bits
    vecs[0]  = mk(4'h0, 10, 10, 10, 10, 10, 10, 1, 2, 3, 4, 5, 4'hF, 120, 0);
    // alignment plus lane masking
    vecs[1]  = mk(4'h0, 12, 10, 8, 12, 12, 12, 8, 1, 0, 0, 0, 4'b0011, 16, 1);
    // shift far beyond the lane width
    vecs[2]  = mk(4'h0, 60, 10, 60, 60, 60, 60, -4, 0, 0, 0, 0, 4'hF, 0, 1);
    // same data, no shift, negative value
    vecs[3]  = mk(4'h0, 60, 60, 60, 60, 60, 60, -4, 0, 0, 0, 0, 4'hF, -32, 0);
    // integer mode ignores exponents and guard bits
    vecs[4]  = mk(4'b1000, 1, 3, 99, 0, 7, 500, 1, 2, 3, 4, 5, 4'hF, 15, 0);
    // masked lanes ignored, C lane always counted
    vecs[5]  = mk(4'h0, 10, 10, 10, 10, 10, 10, 7, 7, 7, 7, 7, 4'b0101, 168, 0);
    // arithmetic shifts of negative lanes without loss: -12 + -2 + 5
    vecs[6]  = mk(4'h0, 11, 10, 9, 11, 11, 8, -3, -1, 0, 0, 5, 4'hF, -9, 0);
    // partial shift losing a bit: 24 >> 4 = 1
    vecs[7]  = mk(4'h0, 4, 4, 4, 4, 4, 0, 0, 0, 0, 0, 3, 4'hF, 1, 1);
    // shift WA-1 keeps the sign
    vecs[8]  = mk(4'h0, 27, 0, 27, 27, 27, 27, -1, 0, 0, 0, 0, 4'hF, -1, 1);
    // shift exactly WA flushes to zero
    vecs[9]  = mk(4'h0, 28, 0, 28, 28, 28, 28, -1, 0, 0, 0, 0, 4'hF, 0, 1);
    // full-scale negative on every lane: 5 * -2^27
    vecs[10] = mk(4'h0, 5, 5, 5, 5, 5, 5, -16777216, -16777216, -16777216, -16777216,
                  -16777216, 4'hF, -671088640, 0);

    reset      = 1'b1;
    valid_in   = 1'b0;
    ready_out  = 1'b1;
    req_id     = '0;
    fmt_s      = '0;
    max_exp    = '0;
    exponents  = '0;
    raw_sigs   = '0;
    exceptions = '0;
    lane_mask  = '0;
    repeat (2) @(negedge clk);
    check("reset valid_out", valid_out, 0);
    check("reset sum_out", sum_out, 0);
    check("reset req_id_out", req_id_out, 0);
    check("reset ready_in", ready_in, 1);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) apply_vec(i);

    // Backpressure: four back-to-back beats, consumer stalls 5 cycles on the first result
    begin
      int  next_beat  = 1;
      int  exp_id     = 1;
      int  stall_left = 0;
      bit  seen_first = 0;
      bit  saw_low    = 0;
      bit  prev_stall = 0;
      logic [31:0]      prev_id  = '0;
      logic [SUM_W-1:0] prev_sum = '0;
      @(negedge clk);
      ready_out = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (c > 0) @(negedge clk);
        if (valid_out && !seen_first) begin
          seen_first = 1;
          stall_left = 5;
        end
        ready_out = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (prev_stall) begin
          check("stall valid held", valid_out, 1);
          check("stall req_id held", req_id_out, prev_id);
          check("stall sum held", sum_out, prev_sum);
        end
        if (next_beat <= 4) drive_c_beat(next_beat, next_beat);
        else valid_in = 1'b0;
        #1;
        if (!ready_in) saw_low = 1;
        if (valid_out && ready_out) begin
          check("bp req_id order", req_id_out, exp_id);
          check("bp sum", longint'($signed(sum_out)), exp_id * 8);
          exp_id++;
        end
        if (valid_in && ready_in) next_beat++;
        prev_stall = valid_out && !ready_out;
        prev_id    = req_id_out;
        prev_sum   = sum_out;
      end
      check("bp all delivered", exp_id, 5);
      check("bp ready_in dropped", saw_low, 1);
    end

    // Reset mid-flight: two beats in the pipe are discarded
    begin
      int outs  = 0;
      int out_j = -1;
      @(negedge clk);
      ready_out = 1'b1;
      drive_c_beat(50, 3);
      @(negedge clk);
      drive_c_beat(51, 3);
      @(negedge clk);
      valid_in = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check("mid reset valid_out", valid_out, 0);
      check("mid reset sum_out", sum_out, 0);
      check("mid reset req_id_out", req_id_out, 0);
      check("mid reset sticky_out", sticky_out, 0);
      check("mid reset ready_in", ready_in, 1);
      reset = 1'b0;
      drive_c_beat(77, 2);
      #1;
      check("post reset ready_in", ready_in, 1);
      @(negedge clk);
      valid_in = 1'b0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (valid_out) begin
          outs++;
          if (out_j < 0) out_j = j;
          check("post reset req_id_out", req_id_out, 77);
          check("post reset sum", longint'($signed(sum_out)), 16);
        end
      end
      check("post reset output count", outs, 1);
      check("post reset latency", out_j, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
